// File: rtl/cic_rate_ctrl.sv
// cic_rate_ctrl
//
// Sequencer that owns the rate port of a variable-rate CIC decimator and
// changes the decimation ratio without corrupting the output stream. A rate
// change stalls the sample source, waits for the decimator pipeline to empty,
// issues the new rate, then hides the transient output samples that follow.
// Only valid/ready are gated; sample data bypasses this block.
//
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   s_axis_cfg_*        rate request from the configuration master
//   in_tvalid/in_tready sample handshake with the source (tready is the stall)
//   cic_in_tvalid       qualified sample valid into the decimator
//   m_axis_rate_*       rate word and load strobe into the decimator
//   cic_out_tvalid      decimator output valid
//   out_tvalid          output valid to downstream, transients suppressed
//   busy                high in every state except RUN
//   cur_rate            rate currently programmed
//   cfg_err             one-cycle pulse after an out-of-range request

module cic_rate_ctrl #(
  parameter int unsigned RATE_DW        = 32,
  parameter int unsigned CIC_R          = 10,
  parameter int unsigned CIC_N          = 7,
  parameter int unsigned FLUSH_CYCLES   = 8,
  parameter int unsigned SETTLE_SAMPLES = CIC_N
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [RATE_DW-1:0] s_axis_cfg_tdata,
  input  logic               s_axis_cfg_tvalid,
  output logic               s_axis_cfg_tready,
  input  logic               in_tvalid,
  output logic               in_tready,
  output logic               cic_in_tvalid,
  output logic [RATE_DW-1:0] m_axis_rate_tdata,
  output logic               m_axis_rate_tvalid,
  input  logic               cic_out_tvalid,
  output logic               out_tvalid,
  output logic               busy,
  output logic [RATE_DW-1:0] cur_rate,
  output logic               cfg_err
);

  localparam int unsigned FlushW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int unsigned SettleW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES + 1) : 1;

  localparam logic [FlushW-1:0]  FlushLast  = FlushW'(FLUSH_CYCLES - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_SAMPLES - 1);
  localparam logic [RATE_DW-1:0] RateMax    = RATE_DW'(CIC_R);

  typedef enum logic [2:0] {
    StInit,
    StLoad,
    StSettle,
    StRun,
    StDrain
  } state_e;

  state_e               state_q;
  logic [RATE_DW-1:0]   rate_q;
  logic [FlushW-1:0]    drain_cnt_q;
  logic [SettleW-1:0]   settle_cnt_q;
  logic                 cfg_err_q;

  logic cfg_hs;
  logic rate_ok;
  logic rate_same;

  assign cfg_hs    = s_axis_cfg_tvalid && (state_q == StRun) && reset_n;
  assign rate_ok   = (s_axis_cfg_tdata != '0) && (s_axis_cfg_tdata <= RateMax);
  assign rate_same = (s_axis_cfg_tdata == rate_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StInit;
      rate_q       <= RateMax;
      drain_cnt_q  <= '0;
      settle_cnt_q <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      unique case (state_q)
        // Always load once out of reset: the decimator's scale factor resets to 0.
        StInit: state_q <= StLoad;
        StLoad: begin
          settle_cnt_q <= '0;
          state_q      <= StSettle;
        end
        StSettle: begin
          if (SETTLE_SAMPLES == 0) begin
            state_q <= StRun;
          end else if (cic_out_tvalid) begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
            if (settle_cnt_q == SettleLast) begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (cfg_hs) begin
            if (!rate_ok) begin
              cfg_err_q <= 1'b1;
            end else if (!rate_same) begin
              rate_q      <= s_axis_cfg_tdata;
              drain_cnt_q <= '0;
              state_q     <= StDrain;
            end
          end
        end
        StDrain: begin
          drain_cnt_q <= drain_cnt_q + 1'b1;
          if (drain_cnt_q == FlushLast) begin
            state_q <= StLoad;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  // Handshake outputs are also forced low while reset is held, so they read
  // as idle even before the first reset edge has been seen.
  always_comb begin
    s_axis_cfg_tready  = reset_n && (state_q == StRun);
    in_tready          = reset_n && ((state_q == StSettle) || (state_q == StRun));
    cic_in_tvalid      = in_tvalid && in_tready;
    m_axis_rate_tvalid = reset_n && (state_q == StLoad);
    // Old-rate samples still in flight during DRAIN are genuine and are passed.
    out_tvalid         = reset_n && cic_out_tvalid &&
                         ((state_q == StRun) || (state_q == StDrain));
    busy               = !reset_n || (state_q != StRun);
    cfg_err            = reset_n && cfg_err_q;
  end

  assign cur_rate          = rate_q;
  assign m_axis_rate_tdata = rate_q;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
module tb_cic_rate_ctrl;

  localparam int unsigned RATE_DW = 32;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [RATE_DW-1:0] s_axis_cfg_tdata;
  logic               s_axis_cfg_tvalid;
  logic               s_axis_cfg_tready;
  logic               in_tvalid;
  logic               in_tready;
  logic               cic_in_tvalid;
  logic [RATE_DW-1:0] m_axis_rate_tdata;
  logic               m_axis_rate_tvalid;
  logic               cic_out_tvalid;
  logic               out_tvalid;
  logic               busy;
  logic [RATE_DW-1:0] cur_rate;
  logic               cfg_err;

  cic_rate_ctrl #(
    .RATE_DW       (RATE_DW),
    .CIC_R         (10),
    .CIC_N         (7),
    .FLUSH_CYCLES  (8),
    .SETTLE_SAMPLES(7)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .s_axis_cfg_tdata  (s_axis_cfg_tdata),
    .s_axis_cfg_tvalid (s_axis_cfg_tvalid),
    .s_axis_cfg_tready (s_axis_cfg_tready),
    .in_tvalid         (in_tvalid),
    .in_tready         (in_tready),
    .cic_in_tvalid     (cic_in_tvalid),
    .m_axis_rate_tdata (m_axis_rate_tdata),
    .m_axis_rate_tvalid(m_axis_rate_tvalid),
    .cic_out_tvalid    (cic_out_tvalid),
    .out_tvalid        (out_tvalid),
    .busy              (busy),
    .cur_rate          (cur_rate),
    .cfg_err           (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [RATE_DW-1:0] data;
    int                 at_cyc;
  } rate_exp_t;

  rate_exp_t rate_q[$];
  logic      out_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One decimator output pulse; exp says whether it should reach out_tvalid.
  task automatic cic_pulse(input logic exp);
    out_q.push_back(exp);
    cic_out_tvalid = 1'b1;
    tick();
    cic_out_tvalid = 1'b0;
  endtask

  // Scoreboard side: compare DUT-produced events against queued expectations.
  always @(negedge clk) begin
    if (m_axis_rate_tvalid === 1'b1) begin
      if (rate_q.size() == 0) begin
        chk("rate_pulse_spurious", 64'(m_axis_rate_tvalid), 64'd0);
      end else begin
        rate_exp_t e;
        e = rate_q.pop_front();
        chk("rate_pulse_data", 64'(m_axis_rate_tdata), 64'(e.data));
        chk("rate_pulse_cycle", 64'(cyc), 64'(e.at_cyc));
      end
    end
    if (cic_out_tvalid === 1'b1) begin
      if (out_q.size() == 0) begin
        chk("out_pulse_unscored", 64'(out_tvalid), 64'd0);
      end else begin
        logic e;
        e = out_q.pop_front();
        chk("out_tvalid_gate", 64'(out_tvalid), 64'(e));
      end
    end
  end

  int t_hs;

  initial begin
    reset_n           = 1'b0;
    s_axis_cfg_tdata  = '0;
    s_axis_cfg_tvalid = 1'b0;
    in_tvalid         = 1'b1;
    cic_out_tvalid    = 1'b0;

    // Reset values.
    repeat (3) tick();
    chk("rst_cfg_tready", 64'(s_axis_cfg_tready), 64'd0);
    chk("rst_in_tready", 64'(in_tready), 64'd0);
    chk("rst_cic_in_tvalid", 64'(cic_in_tvalid), 64'd0);
    chk("rst_rate_tvalid", 64'(m_axis_rate_tvalid), 64'd0);
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_cur_rate", 64'(cur_rate), 64'd10);
    chk("rst_rate_tdata", 64'(m_axis_rate_tdata), 64'd10);

    // Release: INIT now, LOAD after the next edge, SETTLE after the one after.
    rate_q.push_back('{data: 32'd10, at_cyc: cyc + 1});
    reset_n = 1'b1;
    #1;
    chk("init_rate_tvalid", 64'(m_axis_rate_tvalid), 64'd0);
    chk("init_busy", 64'(busy), 64'd1);
    tick();
    chk("load_in_tready", 64'(in_tready), 64'd0);
    tick();
    chk("settle_in_tready", 64'(in_tready), 64'd1);
    chk("settle_cic_in_tvalid", 64'(cic_in_tvalid), 64'd1);
    chk("settle_cfg_tready", 64'(s_axis_cfg_tready), 64'd0);

    // Seven settle samples hidden, eighth passed.
    for (int i = 0; i < 7; i++) begin
      chk("settle_busy", 64'(busy), 64'd1);
      cic_pulse(1'b0);
    end
    chk("run_busy", 64'(busy), 64'd0);
    cic_pulse(1'b1);

    // Out-of-range requests: accepted, flagged, rate unchanged.
    s_axis_cfg_tvalid = 1'b1;
    s_axis_cfg_tdata  = 32'd0;
    #1;
    chk("run_cfg_tready", 64'(s_axis_cfg_tready), 64'd1);
    tick();
    s_axis_cfg_tvalid = 1'b0;
    chk("err0_pulse", 64'(cfg_err), 64'd1);
    chk("err0_busy", 64'(busy), 64'd0);
    chk("err0_rate", 64'(cur_rate), 64'd10);
    tick();
    chk("err0_pulse_end", 64'(cfg_err), 64'd0);
    s_axis_cfg_tvalid = 1'b1;
    s_axis_cfg_tdata  = 32'd11;
    tick();
    s_axis_cfg_tvalid = 1'b0;
    chk("err11_pulse", 64'(cfg_err), 64'd1);
    chk("err11_rate", 64'(cur_rate), 64'd10);
    tick();
    chk("err11_pulse_end", 64'(cfg_err), 64'd0);
    chk("err11_busy", 64'(busy), 64'd0);

    // Request equal to the current rate: no effect.
    s_axis_cfg_tvalid = 1'b1;
    s_axis_cfg_tdata  = 32'd10;
    tick();
    s_axis_cfg_tvalid = 1'b0;
    chk("same_cfg_err", 64'(cfg_err), 64'd0);
    chk("same_busy", 64'(busy), 64'd0);
    chk("same_in_tready", 64'(in_tready), 64'd1);

    // Rate change to 5, handshake at edge t_hs.
    s_axis_cfg_tvalid = 1'b1;
    s_axis_cfg_tdata  = 32'd5;
    t_hs = cyc + 1;
    rate_q.push_back('{data: 32'd5, at_cyc: t_hs + 8});
    tick();
    s_axis_cfg_tvalid = 1'b0;
    chk("chg_cur_rate", 64'(cur_rate), 64'd5);
    chk("chg_busy", 64'(busy), 64'd1);
    chk("drain_cfg_tready", 64'(s_axis_cfg_tready), 64'd0);
    chk("drain_cic_in_tvalid", 64'(cic_in_tvalid), 64'd0);
    cic_pulse(1'b1);
    while (cyc < t_hs + 8) begin
      chk("drain_in_tready", 64'(in_tready), 64'd0);
      tick();
    end
    chk("load2_in_tready", 64'(in_tready), 64'd0);
    tick();
    chk("settle2_in_tready", 64'(in_tready), 64'd1);

    // Request held through SETTLE waits, then goes on the first RUN cycle.
    s_axis_cfg_tvalid = 1'b1;
    s_axis_cfg_tdata  = 32'd3;
    for (int i = 0; i < 7; i++) begin
      chk("settle2_cfg_tready", 64'(s_axis_cfg_tready), 64'd0);
      cic_pulse(1'b0);
    end
    chk("run2_cfg_tready", 64'(s_axis_cfg_tready), 64'd1);
    chk("run2_busy", 64'(busy), 64'd0);
    tick();
    s_axis_cfg_tvalid = 1'b0;
    chk("chg3_cur_rate", 64'(cur_rate), 64'd3);
    chk("chg3_busy", 64'(busy), 64'd1);

    // Reset during the fourth DRAIN cycle abandons rate 3.
    repeat (3) tick();
    chk("drain4_in_tready", 64'(in_tready), 64'd0);
    reset_n = 1'b0;
    tick();
    chk("rst2_cur_rate", 64'(cur_rate), 64'd10);
    chk("rst2_busy", 64'(busy), 64'd1);
    chk("rst2_in_tready", 64'(in_tready), 64'd0);
    tick();
    rate_q.push_back('{data: 32'd10, at_cyc: cyc + 1});
    reset_n = 1'b1;
    tick();
    chk("rst2_load_in_tready", 64'(in_tready), 64'd0);
    tick();
    chk("rst2_settle_in_tready", 64'(in_tready), 64'd1);
    for (int i = 0; i < 7; i++) cic_pulse(1'b0);
    cic_pulse(1'b1);
    chk("rst2_run_busy", 64'(busy), 64'd0);
    repeat (12) tick();

    chk("rate_events_left", 64'(rate_q.size()), 64'd0);
    chk("out_events_left", 64'(out_q.size()), 64'd0);
    chk("final_cur_rate", 64'(cur_rate), 64'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cic_rate_ctrl.md
# cic_rate_ctrl

Sequencer for the variable-rate CIC decimator (`VARIABLE_RATE = 1`). It owns the decimator's rate port and changes the decimation ratio safely. To do that it stalls the upstream sample stream, drains the integrator/scaling pipeline, issues the new rate, and discards the transient output samples that follow. It sits between the configuration master, the sample source and the decimator, and gates only valid/ready; sample data bypasses it.

## Interface
Parameters:
- `RATE_DW`, 32, width of rate words; equals the decimator's `RATE_DW`.
- `CIC_R`, 10, maximum decimation ratio; also the reset rate.
- `CIC_N`, 7, number of decimator stages (informational; sets the default of `SETTLE_SAMPLES`).
- `FLUSH_CYCLES`, 8, cycles the input is stalled before a rate load. Must be ≥ 1. Covers the 3-stage scaling pipelines plus the integrator register.
- `SETTLE_SAMPLES`, `CIC_N`, number of decimator output samples discarded after a rate load. 0 is legal.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset; synchronous, active-low.
- `s_axis_cfg_tdata`  in  `RATE_DW`  requested decimation ratio, unsigned.
- `s_axis_cfg_tvalid`  in  1  request valid.
- `s_axis_cfg_tready`  out  1  request accepted when high with tvalid.
- `in_tvalid`  in  1  sample valid from the source.
- `in_tready`  out  1  stall to the source.
- `cic_in_tvalid`  out  1  `in_tvalid & in_tready`, drives decimator `s_axis_in_tvalid`.
- `m_axis_rate_tdata`  out  `RATE_DW`  to decimator `s_axis_rate_tdata`.
- `m_axis_rate_tvalid`  out  1  to decimator `s_axis_rate_tvalid`.
- `cic_out_tvalid`  in  1  decimator `m_axis_out_tvalid`.
- `out_tvalid`  out  1  gated output valid to downstream.
- `busy`  out  1  high in every state except RUN.
- `cur_rate`  out  `RATE_DW`  rate currently programmed.
- `cfg_err`  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: INIT, LOAD, SETTLE, RUN, DRAIN. All outputs except `cur_rate`/`m_axis_rate_tdata` are combinational decodes of the state register and inputs. `cfg_err` and the counters are registers.
- Reset (`reset_n` low at a clk edge):
  - state goes to INIT; `cur_rate` and `m_axis_rate_tdata` are set to `CIC_R`.
  - Both counters are cleared and `cfg_err` is 0.
  - Reset mid-operation abandons any drain or settle in progress immediately.
- INIT: all handshake outputs are 0. Next state is LOAD. This forces an initial rate load so the decimator's scaling factor is never left at its reset value of 0.
- LOAD: `m_axis_rate_tvalid` = 1 for exactly one cycle, with `m_axis_rate_tdata` = `cur_rate`. `in_tready` = 0. Next state is SETTLE with the settle counter at 0.
- SETTLE:
  - `in_tready` = 1 and `out_tvalid` = 0.
  - Each `cic_out_tvalid` pulse increments the settle counter.
  - On the pulse that brings the count to `SETTLE_SAMPLES`, the next state is RUN; that pulse is also suppressed.
  - If `SETTLE_SAMPLES` = 0, the next state is RUN immediately.
- RUN:
  - `in_tready` = 1, `out_tvalid` = `cic_out_tvalid`, `s_axis_cfg_tready` = 1.
  - On a handshake with rate R:
    - 1 ≤ R ≤ `CIC_R` and R ≠ `cur_rate`: latch R into `cur_rate`/`m_axis_rate_tdata`, clear the drain counter, go to DRAIN.
    - R = `cur_rate`: accept with no other effect; stay in RUN.
    - R = 0 or R > `CIC_R`: accept, pulse `cfg_err` next cycle, stay in RUN, rate unchanged.
- DRAIN:
  - `in_tready` = 0 and `out_tvalid` = `cic_out_tvalid`; old-rate samples still in flight are valid and are passed.
  - The drain counter increments every cycle. After `FLUSH_CYCLES` cycles in DRAIN, the next state is LOAD.
- `s_axis_cfg_tready` = 0 in every state except RUN; requests there wait.
- `cic_in_tvalid` is never high while `in_tready` is low.

## Timing
- Reset values while `reset_n` is low: `s_axis_cfg_tready`, `in_tready`, `cic_in_tvalid`, `m_axis_rate_tvalid`, `out_tvalid` and `cfg_err` all 0. `busy` = 1; `cur_rate` and `m_axis_rate_tdata` = `CIC_R`.
- After reset release, with first post-reset edge E0:
  - INIT during cycle 0, LOAD during cycle 1 (rate valid), SETTLE from cycle 2.
- Rate change, config handshake at edge T while in RUN:
  - DRAIN covers cycles T+1 … T+`FLUSH_CYCLES`; `in_tready` is low across them.
  - LOAD at cycle T+`FLUSH_CYCLES`+1.
  - SETTLE from T+`FLUSH_CYCLES`+2.
- `cfg_err` is high for the single cycle after a rejected handshake.
- `busy` rises the cycle after an accepted change and falls the first cycle of RUN.
- Counters are wide enough for `FLUSH_CYCLES` and `SETTLE_SAMPLES`; there is no wrap-around in use.

## Test plan
- Reset, defaults (`FLUSH_CYCLES` = 8, `SETTLE_SAMPLES` = 7), release reset:
  - exactly one `m_axis_rate_tvalid` pulse with data 10, at cycle 1;
  - the first 7 `cic_out_tvalid` pulses are suppressed and the 8th appears on `out_tvalid`;
  - `busy` falls after the 7th.
- In RUN, config 5 accepted at T:
  - `in_tready` low for cycles T+1…T+8;
  - rate pulse with data 5 at T+9;
  - next 7 outputs suppressed; `cur_rate` = 5 from T+1.
- Invalid requests in RUN, config 0 then 11:
  - both accepted;
  - `cfg_err` pulses once after each;
  - no rate pulse; `cur_rate` unchanged; `busy` stays low.
- Config equal to `cur_rate`: accepted, no DRAIN, no rate pulse, no `cfg_err`.
- Config tvalid held during SETTLE: `s_axis_cfg_tready` = 0 until RUN, then accepted on the first RUN cycle.
- Reset asserted at cycle 4 of DRAIN:
  - next state INIT and `cur_rate` = 10;
  - the full reset sequence repeats;
  - the abandoned rate is never issued.
